// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
// mips_isa_pkg : instruction classes, opcodes and funct codes shared by the
//                encoder and the main control decoder.  Rev 1.0
// ============================================================================
package mips_isa_pkg;

    typedef enum logic [3:0] {
        CLS_ADD  = 4'd0,
        CLS_SUB  = 4'd1,
        CLS_AND  = 4'd2,
        CLS_OR   = 4'd3,
        CLS_SLT  = 4'd4,
        CLS_LW   = 4'd5,
        CLS_SW   = 4'd6,
        CLS_BEQ  = 4'd7,
        CLS_ADDI = 4'd8,
        CLS_J    = 4'd9
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [4:0] SHAMT_ZERO = 5'd0;

endpackage : mips_isa_pkg
`default_nettype wire

// File: rtl/mips_word_pack.sv
`default_nettype none
// ============================================================================
// mips_word_pack : combinational class/fields to 32-bit MIPS word, with an
//                  illegal-class flag.  Rev 1.0
// ============================================================================
module mips_word_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  cls_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] instr_o,
    output logic        illegal_o
);

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, SHAMT_ZERO, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    always_comb begin
        instr_o   = 32'd0;
        illegal_o = 1'b0;
        case (cls_i)
            CLS_ADD:  instr_o = rtype(rs_i, rt_i, rd_i, FUNCT_ADD);
            CLS_SUB:  instr_o = rtype(rs_i, rt_i, rd_i, FUNCT_SUB);
            CLS_AND:  instr_o = rtype(rs_i, rt_i, rd_i, FUNCT_AND);
            CLS_OR:   instr_o = rtype(rs_i, rt_i, rd_i, FUNCT_OR);
            CLS_SLT:  instr_o = rtype(rs_i, rt_i, rd_i, FUNCT_SLT);
            CLS_LW:   instr_o = itype(OP_LW,   rs_i, rt_i, imm_i);
            CLS_SW:   instr_o = itype(OP_SW,   rs_i, rt_i, imm_i);
            CLS_BEQ:  instr_o = itype(OP_BEQ,  rs_i, rt_i, imm_i);
            CLS_ADDI: instr_o = itype(OP_ADDI, rs_i, rt_i, imm_i);
            CLS_J:    instr_o = {OP_J, target_i};
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule : mips_word_pack
`default_nettype wire

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// mips_instr_encoder : valid/ready instruction encoder with a 2-entry output
//                      FIFO of {word, byte address}.  Rev 1.0
// ============================================================================
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int AW        = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_class,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [AW-1:0] out_addr,
    output logic          err_illegal,
    output logic [15:0]   n_emitted
);

    localparam logic [AW-1:0] C_BASE = AW'(BASE_ADDR);
    localparam logic [AW-1:0] C_STEP = AW'(4);

    logic [31:0]   w_word;
    logic          w_illegal;
    logic          w_accept, w_push, w_pop;

    logic [1:0]    count_q, count_d;
    logic [31:0]   head_instr_q, head_instr_d;
    logic [AW-1:0] head_addr_q, head_addr_d;
    logic [31:0]   tail_instr_q, tail_instr_d;
    logic [AW-1:0] tail_addr_q, tail_addr_d;
    logic [AW-1:0] next_addr_q, next_addr_d;
    logic          err_q, err_d;
    logic [15:0]   emitted_q, emitted_d;

    mips_word_pack u_pack (
        .cls_i     (in_class),
        .rs_i      (in_rs),
        .rt_i      (in_rt),
        .rd_i      (in_rd),
        .imm_i     (in_imm),
        .target_i  (in_target),
        .instr_o   (w_word),
        .illegal_o (w_illegal)
    );

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready    = (count_q != 2'd2);
    assign out_valid   = (count_q != 2'd0);
    assign out_instr   = head_instr_q;
    assign out_addr    = head_addr_q;
    assign err_illegal = err_q;
    assign n_emitted   = emitted_q;

    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & ~w_illegal;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_addr_d  = head_addr_q;
        tail_instr_d = tail_instr_q;
        tail_addr_d  = tail_addr_q;
        next_addr_d  = next_addr_q;
        err_d        = err_q | (w_accept & w_illegal);
        emitted_d    = w_pop ? emitted_q + 16'd1 : emitted_q;

        if (w_push) begin
            next_addr_d = next_addr_q + C_STEP;
        end

        case ({w_push, w_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_instr_d = w_word;
                    head_addr_d  = next_addr_q;
                end else begin
                    tail_instr_d = w_word;
                    tail_addr_d  = next_addr_q;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                // Head keeps its last value when draining to empty.
                if (count_q == 2'd2) begin
                    head_instr_d = tail_instr_q;
                    head_addr_d  = tail_addr_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Push with pop only happens at occupancy 1.
                head_instr_d = w_word;
                head_addr_d  = next_addr_q;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= 2'd0;
            head_instr_q <= 32'd0;
            head_addr_q  <= C_BASE;
            tail_instr_q <= 32'd0;
            tail_addr_q  <= C_BASE;
            next_addr_q  <= C_BASE;
            err_q        <= 1'b0;
            emitted_q    <= 16'd0;
        end else begin
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_addr_q  <= head_addr_d;
            tail_instr_q <= tail_instr_d;
            tail_addr_q  <= tail_addr_d;
            next_addr_q  <= next_addr_d;
            err_q        <= err_d;
            emitted_q    <= emitted_d;
        end
    end

endmodule : mips_instr_encoder
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// tb_mips_instr_encoder : directed self-checking bench for the encoder, with
//                         a second narrow-address instance for wrap.  Rev 1.0
// ============================================================================
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_class;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_ready;

    logic        in_ready, out_valid, err_illegal;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic [15:0] n_emitted;

    logic        w_in_ready, w_out_valid, w_err_illegal;
    logic [31:0] w_out_instr;
    logic [3:0]  w_out_addr;
    logic [15:0] w_n_emitted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_instr_encoder #(.AW(8), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err_illegal(err_illegal), .n_emitted(n_emitted)
    );

    mips_instr_encoder #(.AW(4), .BASE_ADDR(8)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_instr(w_out_instr), .out_addr(w_out_addr),
        .err_illegal(w_err_illegal), .n_emitted(w_n_emitted)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        in_valid  = 1'b1;
        in_class  = cls;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b1;
        in_valid = 1'b0; in_class = 4'd0; in_rs = 5'd0; in_rt = 5'd0;
        in_rd = 5'd0; in_imm = 16'd0; in_target = 26'd0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_out_instr", out_instr,       32'd0);
        check_eq("rst_out_addr",  32'(out_addr),  32'd0);
        check_eq("rst_err",       32'(err_illegal), 32'd0);
        check_eq("rst_n_emitted", 32'(n_emitted), 32'd0);
        check_eq("rst_w_out_addr", 32'(w_out_addr), 32'h8);
        reset = 1'b0;

        // ADD rs=1 rt=2 rd=3, latency 1
        drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        @(negedge clk); idle();
        check_eq("add_valid", 32'(out_valid), 32'd1);
        check_eq("add_instr", out_instr, 32'h00221820);
        check_eq("add_addr",  32'(out_addr), 32'h00);
        @(negedge clk);
        check_eq("add_emitted", 32'(n_emitted), 32'd1);
        check_eq("add_drained", 32'(out_valid), 32'd0);

        // LW then BEQ back-to-back
        do_reset();
        drive(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
        @(negedge clk);
        check_eq("lw_instr", out_instr, 32'h8FA80004);
        check_eq("lw_addr",  32'(out_addr), 32'h00);
        drive(4'd7, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'h0);
        @(negedge clk); idle();
        check_eq("beq_valid", 32'(out_valid), 32'd1);
        check_eq("beq_instr", out_instr, 32'h1085FFFF);
        check_eq("beq_addr",  32'(out_addr), 32'h04);
        @(negedge clk);
        check_eq("lwbeq_emitted", 32'(n_emitted), 32'd2);

        // Backpressure: three requests with out_ready low
        do_reset();
        out_ready = 1'b0;
        drive(4'd8, 5'd0, 5'd2, 5'd0, 16'h0005, 26'h0);
        @(negedge clk);
        check_eq("bp_ready1", 32'(in_ready), 32'd1);
        drive(4'd1, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0);
        @(negedge clk);
        check_eq("bp_full_ready", 32'(in_ready), 32'd0);
        check_eq("bp_head", out_instr, 32'h20020005);
        drive(4'd3, 5'd6, 5'd7, 5'd8, 16'h0, 26'h0);
        @(negedge clk);
        check_eq("bp_hold_ready", 32'(in_ready), 32'd0);
        check_eq("bp_hold_head", out_instr, 32'h20020005);
        check_eq("bp_hold_addr", 32'(out_addr), 32'h00);
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_pop1_ready", 32'(in_ready), 32'd1);
        check_eq("bp_sub_instr", out_instr, 32'h00642822);
        check_eq("bp_sub_addr",  32'(out_addr), 32'h04);
        @(negedge clk); idle();
        check_eq("bp_or_instr", out_instr, 32'h00C74025);
        check_eq("bp_or_addr",  32'(out_addr), 32'h08);
        @(negedge clk);
        check_eq("bp_empty", 32'(out_valid), 32'd0);
        check_eq("bp_emitted", 32'(n_emitted), 32'd3);
        check_eq("bp_last_held", out_instr, 32'h00C74025);

        // Illegal class between two jumps
        do_reset();
        drive(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
        @(negedge clk);
        check_eq("j1_instr", out_instr, 32'h08100000);
        check_eq("j1_addr",  32'(out_addr), 32'h00);
        check_eq("j1_err",   32'(err_illegal), 32'd0);
        drive(4'd12, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
        @(negedge clk);
        check_eq("ill_err",   32'(err_illegal), 32'd1);
        check_eq("ill_empty", 32'(out_valid), 32'd0);
        drive(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
        @(negedge clk); idle();
        check_eq("j2_instr", out_instr, 32'h08100000);
        check_eq("j2_addr",  32'(out_addr), 32'h04);
        @(negedge clk);
        check_eq("ill_sticky", 32'(err_illegal), 32'd1);
        check_eq("ill_emitted", 32'(n_emitted), 32'd2);

        // Narrow address wrap on the AW=4, BASE_ADDR=8 instance
        do_reset();
        drive(4'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0);
        @(negedge clk);
        check_eq("wrap_a0", 32'(w_out_addr), 32'h8);
        drive(4'd4, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0);
        @(negedge clk);
        check_eq("wrap_a1", 32'(w_out_addr), 32'hC);
        drive(4'd6, 5'd3, 5'd3, 5'd0, 16'h0010, 26'h0);
        @(negedge clk); idle();
        check_eq("wrap_a2", 32'(w_out_addr), 32'h0);
        check_eq("wrap_sw_instr", w_out_instr, 32'hAC630010);

        // Reset with two buffered words and err set
        do_reset();
        out_ready = 1'b0;
        drive(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        @(negedge clk);
        drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        @(negedge clk);
        drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        @(negedge clk); idle();
        check_eq("pre_rst_full", 32'(in_ready), 32'd0);
        check_eq("pre_rst_err",  32'(err_illegal), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_err",   32'(err_illegal), 32'd0);
        out_ready = 1'b1;
        drive(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000);
        @(negedge clk); idle();
        check_eq("post_rst_addr",  32'(out_addr), 32'h00);
        check_eq("post_rst_instr", out_instr, 32'h08100000);
        @(negedge clk);
        check_eq("post_rst_emitted", 32'(n_emitted), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mips_instr_encoder
`default_nettype wire

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Instruction encoder: the producing end of the opcode/funct interface that the main control decoder consumes. It accepts abstract instruction requests over a valid/ready handshake and emits legal 32-bit MIPS words, each tagged with its instruction-memory byte address. Used by the program loader and test harness to fill instruction memory. Supports exactly the decoder's instruction set: R-type (ADD/SUB/AND/OR/SLT), LW, SW, BEQ, ADDI and J.

Parameters:
AW, 8, instruction byte-address width; addresses wrap modulo 2^AW.
BASE_ADDR, 0, first address assigned after reset; must be a multiple of 4.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  request valid.
in_ready  out  1  encoder can accept a request.
in_class  in  4  instruction class; encoding is in the package.
in_rs  in  5  source register.
in_rt  in  5  target register.
in_rd  in  5  destination register; R-type only.
in_imm  in  16  immediate or offset for LW/SW/BEQ/ADDI.
in_target  in  26  jump target for J.
out_valid  out  1  encoded word valid.
out_ready  in  1  consumer accepts the word.
out_instr  out  32  encoded instruction.
out_addr  out  AW  byte address of out_instr.
err_illegal  out  1  sticky flag: an illegal class was presented.
n_emitted  out  16  count of words handed off; wraps.

Behaviour:
- Reset (synchronous, active-high) clears FIFO to empty and sets out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_illegal=0, n_emitted=0, next-address register=BASE_ADDR. Reset mid-transfer discards all buffered words.
- Storage is a 2-entry FIFO holding {instr, addr}.
  - in_ready = (occupancy < 2). No combinational path from out_ready to in_ready.
  - Accept = in_valid & in_ready.
- Encoding (shamt always 0):
  - R-type: op=000000, fields rs|rt|rd|00000|funct. Funct values: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - I-type: op|rs|rt|imm. Opcodes: LW 100011, SW 101011, BEQ 000100, ADDI 001000.
  - J: 000010|target.
  - Fields not used by a class are ignored.
- Legal accept: push {encoded word, next-address}, then next-address += 4, wrapping modulo 2^AW. Word appears at the output the cycle after accept: latency 1 when empty, FIFO order otherwise.
- Illegal class (10..15) accept: nothing is pushed, address is not consumed, and err_illegal goes to 1 the next cycle. err_illegal stays 1 until reset.
- Output: out_valid = FIFO non-empty, and out_instr/out_addr show the head entry. When out_valid & ~out_ready, the head is held stable.
  - Pop = out_valid & out_ready. Each pop increments n_emitted.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - With occupancy 1, the new word becomes head on the next cycle.
  - At occupancy 2, in_ready=0, so only the pop occurs.
- out_instr holds its last value when the FIFO is empty; consumers qualify on out_valid.

Decomposition:
- Package mips_isa_pkg holds:
  - in_class enum: ADD=0, SUB=1, AND=2, OR=3, SLT=4, LW=5, SW=6, BEQ=7, ADDI=8, J=9.
  - Opcode and funct localparams, shared with the control decoder so both ends cannot diverge.
- One natural sub-module, mips_word_pack: a combinational class/fields-to-word function plus an illegal flag.
- FIFO and address logic stay in the top module.

Test Plan:
- ADD rs=1 rt=2 rd=3, out_ready=1 -> next cycle out_valid=1, out_instr=0x00221820, out_addr=0x00; then n_emitted=1.
- LW rt=8 rs=29 imm=4, then BEQ rs=4 rt=5 imm=0xFFFF back-to-back -> 0x8FA80004 @0x00, then 0x1085FFFF @0x04.
- out_ready=0, three requests (ADDI rt=2 imm=5 first) -> in_ready low after 2 accepts, head held at 0x20020005. Release out_ready -> words drain in order; third is accepted only after the first pop.
- in_class=12 between two J target=0x0100000 requests -> err_illegal=1 persists; two words 0x08100000 @0x00 and @0x04, with no address gap.
- AW=4, BASE_ADDR=0x8, 3 legal requests -> addresses 0x8, 0xC, 0x0 (wrap).
- Reset asserted with 2 words buffered -> next cycle out_valid=0, in_ready=1, err_illegal=0; next word gets BASE_ADDR.
